// File: rtl/wb_as_bridge.sv
// Wishbone slave that serialises single 16-bit accesses into AS byte-stream
// command frames and collects the 2-byte read response from the remote bridge.
module wb_as_bridge #(
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  as_data_o,
  output logic        as_dstrb_o,
  input  logic        as_busy_i,
  input  logic [7:0]  as_data_i,
  input  logic        as_dstrb_i
);

  typedef enum logic [2:0] {IDLE, SEND, RESP, DONE, ERR} state_t;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [31:0] adr_q;
  logic [15:0] dat_q;
  logic        we_q;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] rdat, rdat_nxt;
  logic        strb_q;
  logic [7:0]  txd_q;
  logic [7:0]  cur_byte;
  logic        last_byte;
  logic        req;
  logic        sel_unused;

  assign sel_unused = ^wb_sel_i;
  assign req        = wb_cyc_i & wb_stb_i;

  // Frame bytes in wire order; multi-byte fields go LSB first.
  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      3'd0: cur_byte = we_q ? 8'h02 : 8'h01;
      3'd1: cur_byte = adr_q[7:0];
      3'd2: cur_byte = adr_q[15:8];
      3'd3: cur_byte = adr_q[23:16];
      3'd4: cur_byte = adr_q[31:24];
      3'd5: cur_byte = dat_q[7:0];
      3'd6: cur_byte = dat_q[15:8];
      default: cur_byte = 8'h00;
    endcase
  end

  assign last_byte = we_q ? (idx == 3'd6) : (idx == 3'd4);
  assign as_data_o = as_dstrb_o ? cur_byte : txd_q;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    rdat_nxt   = rdat;
    as_dstrb_o = 1'b0;
    wb_ack_o   = 1'b0;
    wb_err_o   = 1'b0;
    wb_dat_o   = 16'h0000;
    case (state)
      IDLE: begin
        if (req) begin
          idx_nxt   = 3'd0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // The gap after every strobe lets the transmitter raise busy.
        if (!as_busy_i && !strb_q) begin
          as_dstrb_o = 1'b1;
          if (!last_byte) begin
            idx_nxt = idx + 3'd1;
          end else if (we_q) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = 16'h0000;
            idx_nxt   = 3'd0;
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        cnt_nxt = cnt + 16'h0001;
        if (as_dstrb_i) begin
          if (idx == 3'd0) begin
            rdat_nxt[7:0] = as_data_i;
            idx_nxt       = 3'd1;
          end else begin
            rdat_nxt[15:8] = as_data_i;
          end
        end
        // A second byte landing on the expiry cycle still wins.
        if (as_dstrb_i && idx == 3'd1) begin
          state_nxt = DONE;
        end else if (cnt == TIMEOUT_W) begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        wb_ack_o  = req;
        wb_dat_o  = we_q ? 16'h0000 : rdat;
        state_nxt = IDLE;
      end
      ERR: begin
        wb_err_o  = req;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= 3'd0;
      cnt    <= 16'h0000;
      rdat   <= 16'h0000;
      strb_q <= 1'b0;
      txd_q  <= 8'h00;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      rdat   <= rdat_nxt;
      strb_q <= as_dstrb_o;
      if (as_dstrb_o) txd_q <= cur_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      adr_q <= 32'h0;
      dat_q <= 16'h0;
      we_q  <= 1'b0;
    end else if (state == IDLE && req) begin
      adr_q <= wb_adr_i;
      dat_q <= wb_dat_i;
      we_q  <= wb_we_i;
    end
  end

endmodule

// File: tb/tb_wb_as_bridge.sv
// Bench for wb_as_bridge: frames, strobe timing, read responses and timeouts are
// predicted from the protocol rules and compared against what the DUT produces.
module tb_wb_as_bridge;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0]  wb_sel_i;
  logic [31:0] wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [7:0]  as_data_o;
  logic        as_dstrb_o;
  logic        as_busy_i;
  logic [7:0]  as_data_i;
  logic        as_dstrb_i;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [7:0]  mon_b[$];
  int          mon_t[$];
  int          ack_t[$];
  logic [15:0] ack_d[$];
  int          err_t[$];
  logic [15:0] err_d[$];

  wb_as_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .as_data_o(as_data_o), .as_dstrb_o(as_dstrb_o), .as_busy_i(as_busy_i),
    .as_data_i(as_data_i), .as_dstrb_i(as_dstrb_i)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (as_dstrb_o) begin mon_b.push_back(as_data_o); mon_t.push_back(cycle); end
    if (wb_ack_o) begin ack_t.push_back(cycle); ack_d.push_back(wb_dat_o); end
    if (wb_err_o) begin err_t.push_back(cycle); err_d.push_back(wb_dat_o); end
    if (wb_ack_o || wb_err_o) chk("ack_err_excl", {31'b0, wb_ack_o & wb_err_o}, 32'h0);
  end

  // One access; the reference schedule is derived from the frame rules, then
  // the stimulus is played cycle by cycle and the observed trace compared.
  task automatic xact(input logic we, input logic [31:0] adr, input logic [15:0] dat,
                      input int n_rx, input logic [15:0] rx, input int g0, input int g1,
                      input int busy_after, input int busy_len, input bit stray,
                      input bit drop, input bit keep);
    logic [7:0] exp_b[$];
    int exp_t[$];
    int n, b0, a0, e0, t_req, bs, be, rs, rx1, rx2, out_kind, out_t, end_t, t;
    bit act;
    exp_b.push_back(we ? 8'h02 : 8'h01);
    for (int i = 0; i < 4; i++) exp_b.push_back(8'(adr >> (8 * i)));
    if (we) begin exp_b.push_back(dat[7:0]); exp_b.push_back(dat[15:8]); end
    n = exp_b.size();
    t_req = cycle;
    bs = -1; be = -2;
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? t_req + 1 : exp_t[i-1] + 2;
      if (busy_len > 0 && i == busy_after) begin
        bs = exp_t[i-1] + 1;
        be = bs + busy_len - 1;
        if (t <= be) t = be + 1;
      end
      exp_t.push_back(t);
    end
    rs = 1 << 30; rx1 = -1; rx2 = -1;
    if (!we) begin
      rs  = exp_t[4] + 1;
      rx1 = rs + g0;
      rx2 = rx1 + 1 + g1;
    end
    if (drop) begin out_kind = 0; out_t = exp_t[n-1] + 1; end
    else if (we) begin out_kind = 1; out_t = exp_t[n-1] + 1; end
    else if (n_rx == 2 && rx2 - rs <= TO) begin out_kind = 1; out_t = rx2 + 1; end
    else begin out_kind = 2; out_t = rs + TO + 1; end
    end_t = out_t;
    if (n_rx >= 1 && rx1 > end_t) end_t = rx1;
    if (n_rx == 2 && rx2 > end_t) end_t = rx2;
    if (!keep) end_t = end_t + 2;
    b0 = mon_b.size(); a0 = ack_t.size(); e0 = err_t.size();

    for (int cur = t_req; cur <= end_t; cur++) begin
      act = drop ? (cur < t_req + 2) : (keep || cur <= out_t);
      wb_cyc_i = act; wb_stb_i = act;
      wb_sel_i = 2'($urandom);
      if (cur == t_req) begin
        wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
      end else begin
        wb_we_i = 1'($urandom); wb_adr_i = $urandom; wb_dat_i = 16'($urandom);
      end
      as_busy_i  = (cur >= bs && cur <= be);
      as_dstrb_i = 1'b0;
      as_data_i  = 8'($urandom);
      if (n_rx >= 1 && cur == rx1) begin as_dstrb_i = 1'b1; as_data_i = rx[7:0]; end
      else if (n_rx == 2 && cur == rx2) begin as_dstrb_i = 1'b1; as_data_i = rx[15:8]; end
      else if (stray && cur < rs && $urandom_range(0, 3) == 0) as_dstrb_i = 1'b1;
      step();
    end
    as_dstrb_i = 1'b0;
    as_busy_i  = 1'b0;

    chk("n_bytes", mon_b.size() - b0, n);
    for (int i = 0; i < n; i++) begin
      if (b0 + i < mon_b.size()) begin
        chk($sformatf("byte%0d_val", i), {24'b0, mon_b[b0+i]}, {24'b0, exp_b[i]});
        chk($sformatf("byte%0d_cyc", i), mon_t[b0+i] - t_req, exp_t[i] - t_req);
      end
    end
    chk("n_ack", ack_t.size() - a0, (out_kind == 1) ? 1 : 0);
    chk("n_err", err_t.size() - e0, (out_kind == 2) ? 1 : 0);
    if (out_kind == 1 && ack_t.size() > a0) begin
      chk("ack_cyc", ack_t[a0] - t_req, out_t - t_req);
      if (!we) chk("ack_dat", {16'b0, ack_d[a0]}, {16'b0, rx});
    end
    if (out_kind == 2 && err_t.size() > e0) begin
      chk("err_cyc", err_t[e0] - t_req, out_t - t_req);
      chk("err_dat", {16'b0, err_d[e0]}, 32'h0);
    end
  endtask

  initial begin
    int b0, a0, e0, t;
    logic w;
    reset = 1'b1;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0;
    wb_adr_i = 0; wb_dat_i = 0; as_busy_i = 0; as_data_i = 0; as_dstrb_i = 0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_as_data", {24'b0, as_data_o}, 32'h0);
    chk("rst_as_dstrb", {31'b0, as_dstrb_o}, 32'h0);
    chk("rst_ack", {31'b0, wb_ack_o}, 32'h0);
    chk("rst_err", {31'b0, wb_err_o}, 32'h0);
    chk("rst_dat", {16'b0, wb_dat_o}, 32'h0);
    step();

    // stray receive bytes while idle
    for (int i = 0; i < 6; i++) begin
      as_dstrb_i = 1'($urandom); as_data_i = 8'($urandom);
      step();
    end
    as_dstrb_i = 1'b0;
    step();

    xact(1'b1, 32'h12345678, 16'hBEEF, 0, 16'h0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    xact(1'b0, 32'h0000A004, 16'h0, 2, 16'hABCD, 2, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    xact(1'b1, $urandom, 16'($urandom), 0, 16'h0, 0, 0, 2, 10, 1'b0, 1'b0, 1'b0);
    // timeout with a single reply byte, then a late second byte, then recovery
    xact(1'b0, $urandom, 16'h0, 1, 16'h5A11, 3, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    xact(1'b0, $urandom, 16'h0, 2, 16'h7E57, 0, 25, 0, 0, 1'b0, 1'b0, 1'b0);
    xact(1'b0, $urandom, 16'h0, 2, 16'h1357, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    // second reply byte exactly on the expiry cycle is accepted
    xact(1'b0, $urandom, 16'h0, 2, 16'hC0DE, 0, TO - 1, 0, 0, 1'b0, 1'b0, 1'b0);
    xact(1'b0, $urandom, 16'h0, 2, 16'h2468, 2, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    xact(1'b1, $urandom, 16'($urandom), 0, 16'h0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    // back-to-back: strobe stays high across the ack
    xact(1'b1, $urandom, 16'($urandom), 0, 16'h0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    xact(1'b1, $urandom, 16'($urandom), 0, 16'h0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    xact(1'b0, $urandom, 16'h0, 2, 16'($urandom), 1, 2, 0, 0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a write frame, right after byte 3
    b0 = mon_b.size(); a0 = ack_t.size(); e0 = err_t.size();
    t = cycle;
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 32'hDEADBEEF; wb_dat_i = 16'h1234;
    repeat (6) step();
    reset = 1'b1; wb_cyc_i = 0; wb_stb_i = 0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_as_data", {24'b0, as_data_o}, 32'h0);
    chk("mrst_as_dstrb", {31'b0, as_dstrb_o}, 32'h0);
    chk("mrst_dat", {16'b0, wb_dat_o}, 32'h0);
    repeat (20) step();
    chk("mrst_n_bytes", mon_b.size() - b0, 3);
    if (mon_b.size() - b0 >= 3) begin
      chk("mrst_b0", {24'b0, mon_b[b0]}, 32'h02);
      chk("mrst_b1", {24'b0, mon_b[b0+1]}, 32'hEF);
      chk("mrst_b2", {24'b0, mon_b[b0+2]}, 32'hBE);
      chk("mrst_b2_cyc", mon_t[b0+2] - t, 5);
    end
    chk("mrst_n_ack", ack_t.size() - a0, 0);
    chk("mrst_n_err", err_t.size() - e0, 0);
    xact(1'b0, $urandom, 16'h0, 2, 16'h0F0F, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    xact(1'b1, $urandom, 16'($urandom), 0, 16'h0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // randomized accesses
    for (int i = 0; i < 12; i++) begin
      w = 1'($urandom);
      xact(w, $urandom, 16'($urandom), w ? 0 : 2, 16'($urandom),
           $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom_range(1, w ? 6 : 4), $urandom_range(0, 5),
           1'($urandom), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_as_bridge.md
# wb_as_bridge

Host-side counterpart of the AS-to-Wishbone bridge. It acts as a Wishbone slave and turns each single 16-bit Wishbone access into the AS byte-stream command protocol toward a remote AS-to-Wishbone bridge. For reads it collects the 2-byte response and returns it on `wb_dat_o`. It sits between a local Wishbone master (e.g. the debug CPU) and the AS serial byte transport (UART/serializer pair).

## Interface
Parameters:
- `TIMEOUT`, default 65535: cycles to wait for a read response before asserting `wb_err_o`. Range 1..65535; the counter is 16 bits.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `wb_cyc_i`  in  1  Wishbone cycle.
- `wb_stb_i`  in  1  Wishbone strobe.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_sel_i`  in  2  ignored; every access is a full 16-bit access.
- `wb_adr_i`  in  32  remote address, forwarded unchanged.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data; valid in the `wb_ack_o` cycle.
- `wb_ack_o`  out  1  single-cycle completion pulse.
- `wb_err_o`  out  1  single-cycle read-timeout pulse.
- `as_data_o`  out  8  transmit byte; valid in the `as_dstrb_o` cycle.
- `as_dstrb_o`  out  1  single-cycle transmit strobe.
- `as_busy_i`  in  1  transmitter busy; no strobe may be issued while it is high.
- `as_data_i`  in  8  received byte.
- `as_dstrb_i`  in  1  single-cycle receive strobe.

## Operation
- Frame format, all multi-byte fields sent LSB first:
  - Write: `0x02`, adr[7:0], adr[15:8], adr[23:16], adr[31:24], dat[7:0], dat[15:8]. 7 bytes, no reply from the remote.
  - Read: `0x01`, adr[7:0], adr[15:8], adr[23:16], adr[31:24]. 5 bytes, then the remote returns 2 bytes: dat[7:0], dat[15:8].
- State machine:
  - IDLE: when `wb_cyc_i & wb_stb_i` is high, latch `wb_adr_i`, `wb_dat_i` and `wb_we_i`, clear byte index, go to SEND.
  - SEND: issue byte[index]. After the last byte (index 6 for a write, index 4 for a read), a write goes to DONE and a read clears the timeout counter and byte index and goes to RESP.
  - RESP:
    - On `as_dstrb_i`, store the byte at index 0 into data[7:0], or at index 1 into data[15:8].
    - After the second byte, go to DONE.
    - If the timeout counter reaches `TIMEOUT` with no second byte, go to ERR.
  - DONE: pulse `wb_ack_o` (and drive `wb_dat_o` for a read), return to IDLE.
  - ERR: pulse `wb_err_o`, `wb_dat_o` = 0, return to IDLE.
- Transmit pacing:
  - A byte is strobed only when in SEND, `as_busy_i` = 0, and `as_dstrb_o` was 0 in the previous cycle.
  - The mandatory one-cycle gap gives the transmitter time to raise busy.
- Receive filtering:
  - `as_dstrb_i` outside RESP is discarded; this covers stray bytes and late bytes after a timeout.
  - A received byte in the same cycle as the timeout expiry is accepted; the timeout only fires if the second byte has not arrived by then.
- Wishbone side:
  - The transaction is latched at acceptance; changes on the inputs afterward are ignored.
  - If `wb_cyc_i` or `wb_stb_i` is low in the DONE/ERR cycle, the frame still completed on the wire, but the `ack`/`err` pulse is suppressed.
  - `wb_ack_o` and `wb_err_o` are never high together.
  - Only one transaction is in flight at a time; a new request is sampled only in IDLE.
- Reset:
  - All outputs go to 0 and the state goes to IDLE.
  - Reset mid-frame abandons the frame with no `ack`/`err`. The remote parser desynchronises; recovery is by remote reset or padding with NOP (`0x00`) bytes, which is a software concern.

## Timing
- Reset values: `as_data_o` = 0, `as_dstrb_o` = 0, `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0.
- Request seen in IDLE at cycle T, with `as_busy_i` held low:
  - First strobe at T+1.
  - Subsequent strobes every 2 cycles.
- Write:
  - Last (7th) strobe at T+13.
  - `wb_ack_o` at T+14.
- Read:
  - 5th strobe at T+9.
  - If the second response strobe is at cycle R, `wb_ack_o` and valid `wb_dat_o` are at R+1.
  - Timeout counter starts at T+10. `wb_err_o` is at T+10+`TIMEOUT`+1 if no second byte arrives.
- `as_busy_i` high stalls SEND indefinitely; `as_data_o` holds its last value.
- Back-to-back accesses: the next request is accepted the cycle after the `ack`, if `stb` is still high.

## Test plan
- Write: adr=0x12345678, dat=0xBEEF, busy low -> bytes 02 78 56 34 12 EF BE on strobes at T+1, T+3 … T+13; `ack` at T+14.
- Read: adr=0x0000A004, remote replies 0xCD then 0xAB -> bytes 01 04 A0 00 00; `ack` with `wb_dat_o`=0xABCD one cycle after the second rx strobe.
- Busy stall: `as_busy_i` high for 10 cycles after byte 2 of a write -> no strobe while busy, byte 3 on the first cycle busy is low, all bytes correct and in order.
- Timeout: `TIMEOUT`=20, read with only one reply byte -> `wb_err_o` pulse 21 cycles after timer start, no `ack`. A late second byte is then ignored, and the next read completes normally.
- Stray rx: `as_dstrb_i` bytes during IDLE and SEND -> ignored; the subsequent read returns only the bytes received in RESP.
- Reset mid-write after byte 3 -> no further strobes, all outputs 0, no `ack`. The next request starts a fresh frame with `0x02`/`0x01`.
